// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, line levels and
// the baud divisor helper.
package uart_pkg;

  // Legacy-compatible state encodings, reused as the enum values below.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_e;

  // Line levels for the framing bits.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Clock cycles per serial bit (integer division, remainder dropped).
  function automatic int unsigned baud_div(input int unsigned clk_frq,
                                           input int unsigned baud_rate);
    return clk_frq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of the transmitter. Power-of-two depth so the pointers
// wrap naturally; a separate occupancy counter tells full from empty.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full queue is
  // still taken when it coincides with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: FIFO in front of a baud counter, framing FSM and
// shift register. The serial line, done pulse and busy flag are all registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRQ    = 250000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned BYTE       = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [BYTE-1:0]               tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          data_out,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_FRQ, BAUD_RATE);
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IDX_W    = (BYTE > 1) ? $clog2(BYTE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [BYTE-1:0]   shift_q, shift_d;
  logic              data_out_q, data_out_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              baud_tc;
  logic              pop;
  logic              push;
  logic [BYTE-1:0]   fifo_data;
  logic              fifo_full;
  logic              fifo_empty;

  uart_tx_fifo #(
    .WIDTH (BYTE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (tx_data),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign baud_tc  = (baud_cnt_q == CNT_LAST);
  // Ready also when full but a pop happens this cycle; pop comes only from
  // registered state, so there is no combinational loop with tx_valid.
  assign tx_ready = !fifo_full || pop;
  assign push     = tx_valid && tx_ready;

  assign data_out = data_out_q;
  assign tx_done  = done_q;
  assign tx_busy  = busy_q;

  // Framing FSM, baud counter and shift register next-state logic.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_tc ? '0 : baud_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        // Counter parked at zero so the start bit always gets a full period.
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          state_d = START;
        end
      end
      START: begin
        if (baud_tc) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_tc) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_tc) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // Output levels, registered one cycle behind the state that produces them.
  always_comb begin
    case (state_q)
      IDLE:    data_out_d = STOP_BIT;
      START:   data_out_d = START_BIT;
      DATA:    data_out_d = shift_q[0];
      STOP:    data_out_d = STOP_BIT;
      default: data_out_d = STOP_BIT;
    endcase
    done_d = (state_q == STOP) && baud_tc;
    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  // State and output registers; reset drops the line high immediately.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_out_q <= STOP_BIT;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FRQ, default 250000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bits/s.
REQ-003 Parameter BYTE, default 8, data bits per frame.
REQ-004 Parameter FIFO_DEPTH, default 4, power of 2 and at least 2, number of queued bytes.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 areset  input  1  reset: asynchronous, active-high.
REQ-007 tx_data  input  BYTE  byte to send.
REQ-008 tx_valid  input  1  tx_data is offered this cycle.
REQ-009 tx_ready  output  1  FIFO not full; a byte is accepted on the clk edge where tx_valid && tx_ready.
REQ-010 data_out  output  1  serial line; idle high.
REQ-011 tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-012 tx_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-014 BAUD_DIV = CLK_FRQ / BAUD_RATE (integer division); each bit is held on data_out for exactly BAUD_DIV cycles.
REQ-015 Frame format: start bit 0, BYTE data bits LSB first, one stop bit 1; a frame lasts (BYTE+2)*BAUD_DIV cycles.
REQ-016 The baud counter restarts at 0 on the cycle a start bit begins, so bit timing never depends on when the byte arrived.
REQ-017 FSM states: IDLE, START, DATA, STOP. Unused encodings go to IDLE with data_out=1.
REQ-018 IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START; data_out goes low on the next cycle.
REQ-019 Transitions on baud-counter terminal count: START to DATA; DATA to STOP after BYTE bits; STOP to START if the FIFO is non-empty (pop in the same cycle, no idle gap), otherwise to IDLE.
REQ-020 data_out is driven from a register, with no combinational path from any input.
REQ-021 Latency: a byte accepted at edge N into an empty FIFO while IDLE drives the start bit on data_out from cycle N+2.
REQ-022 tx_done asserts for the single cycle in which STOP reaches terminal count.
REQ-023 FIFO full: tx_ready=0 and tx_valid is ignored. There is no overwrite, and tx_data must be held by the source.
REQ-024 A push and a pop in the same cycle are both accepted, including when the FIFO is full (after the pop) or empty. fifo_count is then unchanged.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH. fifo_count distinguishes full from empty.
REQ-026 tx_data/tx_valid changes mid-frame do not alter the frame being shifted.

Reset
REQ-027 areset immediately forces data_out=1, tx_busy=0, tx_done=0, tx_ready=1, fifo_count=0, state=IDLE and baud counter=0.
REQ-028 Reset mid-frame aborts the frame and discards all queued bytes; the line returns high asynchronously.
REQ-029 The first frame after reset deassertion starts only after a new push.

Structure
REQ-030 Shared package uart_pkg holds the state enum (IDLE/START/DATA/STOP), START_BIT=0, STOP_BIT=1, and a function computing BAUD_DIV.
REQ-031 The FIFO is a sub-module uart_tx_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count). uart_tx contains the baud counter, FSM and shift register.

Verification (sim params CLK_FRQ=1000, BAUD_RATE=100 so BAUD_DIV=10; BYTE=8; FIFO_DEPTH=4)
REQ-032 Single byte 0xA5 pushed at edge N -> data_out low from cycle N+2 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles; tx_done pulses once at cycle N+101; tx_busy falls after that.
REQ-033 Push 0x00 then 0xFF back-to-back -> two 100-cycle frames with no idle cycle between the stop bit and the second start bit; two tx_done pulses 100 cycles apart.
REQ-034 Push 6 bytes with tx_valid held high -> tx_ready drops when fifo_count=4 while frame 1 is in progress; every byte is transmitted in order and none is lost or duplicated.
REQ-035 FIFO full while a pop occurs with tx_valid=1 -> the push is accepted in the same cycle and fifo_count stays at 4.
REQ-036 areset pulsed at cycle 35 of a frame with 2 bytes queued -> data_out=1 immediately, fifo_count=0, no tx_done pulse; the line stays idle until a new push.
